rc4_stream_xor: RTL

- Consumer end of the RC4 keystream interface: pulls keystream bytes from the RC4 generator over a valid/ready handshake and XORs them with a byte stream of plaintext or ciphertext. Encryption and decryption are the same operation.
- Optionally discards the first DROP_N keystream bytes (RC4-drop[n]).
- Holds keystream in a small FIFO so the generator's two-cycle-per-byte cadence decouples from the data path.
- Sits between the RC4 generator and the host data interface.

---
 rtl/rc4_stream_xor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rc4_stream_xor.sv
// RC4 keystream consumer: buffers generator bytes in a small FIFO, optionally
// discards the first DROP_N of them, and XORs the rest onto the din byte stream.
module rc4_stream_xor #(
    parameter int DROP_N   = 0,
    parameter int KS_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       ks_data,
    input  logic             ks_valid,
    output logic             ks_ready,
    input  logic [7:0]       din_data,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic [7:0]       dout_data,
    output logic             dout_valid,
    output logic             dout_last,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(KS_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DROP  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [15:0] DROP_LAST = (DROP_N > 0) ? 16'(DROP_N - 1) : 16'd0;

    logic [1:0]  state;
    logic [7:0]  fifo_mem [KS_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [15:0] drop_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        ks_fire;
    logic        din_fire;
    logic        dout_fire;
    logic        push;
    logic [7:0]  head;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    always_comb begin
        ks_ready  = 1'b0;
        din_ready = 1'b0;
        case (state)
            S_DROP:  ks_ready = 1'b1;
            S_RUN: begin
                ks_ready  = !fifo_full;
                din_ready = !fifo_empty && (!dout_valid || dout_ready);
            end
            default: begin
                ks_ready  = 1'b0;
                din_ready = 1'b0;
            end
        endcase
    end

    assign ks_fire   = ks_valid && ks_ready;
    assign din_fire  = din_valid && din_ready;
    assign dout_fire = dout_valid && dout_ready;
    assign push      = ks_fire && (state == S_RUN);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= ks_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= '0;
            dout_data  <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            byte_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (din_fire) begin
                rd_ptr     <= rd_ptr + (AW+1)'(1);
                dout_data  <= din_data ^ head;
                dout_last  <= din_last;
                dout_valid <= 1'b1;
            end else if (dout_fire) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
            if (dout_fire) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        drop_cnt <= '0;
                        state    <= (DROP_N > 0) ? S_DROP : S_RUN;
                    end
                end
                S_DROP: begin
                    if (ks_fire) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        if (drop_cnt == DROP_LAST) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (din_fire && din_last) begin
                        state <= S_DRAIN;
                    end
                end
                default: begin
                    // Leftover keystream belongs to this message only, so discard it
                    if (dout_fire) begin
                        state  <= S_IDLE;
                        done   <= 1'b1;
                        rd_ptr <= wr_ptr;
                    end
                end
            endcase
        end
    end

endmodule
